// File: rtl/sm4_cmd_master.sv
// rtl/sm4_cmd_master.sv - command/response sequencer for the sm4_top core handshake
// Takes one {mode, key, block} command at a time and reuses the expanded keys when key and mode repeat.
module sm4_cmd_master #(
  parameter int TIMEOUT      = 1024,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_decrypt,
  input  logic [127:0] cmd_key,
  input  logic [127:0] cmd_data,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [127:0] rsp_data,
  output logic         rsp_error,
  output logic         sm4_enable_out,
  output logic         encdec_enable_out,
  output logic         encdec_sel_out,
  output logic         enable_key_exp_out,
  output logic         user_key_valid_out,
  output logic         valid_out,
  output logic [127:0] user_key_out,
  output logic [127:0] data_out,
  input  logic         key_exp_ready_in,
  input  logic         ready_in,
  input  logic [127:0] result_in
);

  localparam int CW = $clog2(TIMEOUT);
  localparam int FW = $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_KEY_SETUP,
    S_KEY_LOAD,
    S_KEY_WAIT,
    S_DATA_SEND,
    S_DATA_WAIT,
    S_RESP
  } state_t;

  state_t         r_state;
  logic           r_mode;
  logic [127:0]   r_key;
  logic [127:0]   r_data;
  logic           r_cache_vld;
  logic           r_cache_mode;
  logic [127:0]   r_cache_key;
  logic [CW-1:0]  r_cnt;
  logic [FW-1:0]  r_fcnt;

  logic w_hit;
  logic w_expired;

  assign w_hit     = r_cache_vld && (cmd_key == r_cache_key) && (cmd_decrypt == r_cache_mode);
  assign w_expired = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state            <= S_IDLE;
      r_mode             <= 1'b0;
      r_key              <= '0;
      r_data             <= '0;
      r_cache_vld        <= 1'b0;
      r_cache_mode       <= 1'b0;
      r_cache_key        <= '0;
      r_cnt              <= '0;
      r_fcnt             <= '0;
      cmd_ready          <= 1'b0;
      rsp_valid          <= 1'b0;
      rsp_data           <= '0;
      rsp_error          <= 1'b0;
      sm4_enable_out     <= 1'b0;
      encdec_enable_out  <= 1'b0;
      encdec_sel_out     <= 1'b0;
      enable_key_exp_out <= 1'b0;
      user_key_valid_out <= 1'b0;
      valid_out          <= 1'b0;
      user_key_out       <= '0;
      data_out           <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            r_mode    <= cmd_decrypt;
            r_key     <= cmd_key;
            r_data    <= cmd_data;
            if (w_hit) begin
              encdec_enable_out <= 1'b1;
              valid_out         <= 1'b1;
              data_out          <= cmd_data;
              r_state           <= S_DATA_SEND;
            end else begin
              // Core is quiesced so the next key expansion starts from a clean enable edge.
              r_cache_vld        <= 1'b0;
              sm4_enable_out     <= 1'b0;
              enable_key_exp_out <= 1'b0;
              encdec_enable_out  <= 1'b0;
              user_key_valid_out <= 1'b0;
              r_fcnt             <= '0;
              r_state            <= S_FLUSH;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        S_FLUSH: begin
          r_cache_vld <= 1'b0;
          if (r_fcnt == FW'(FLUSH_CYCLES - 1)) begin
            sm4_enable_out     <= 1'b1;
            enable_key_exp_out <= 1'b1;
            encdec_sel_out     <= r_mode;
            r_state            <= S_KEY_SETUP;
          end else begin
            r_fcnt <= r_fcnt + FW'(1);
          end
        end

        S_KEY_SETUP: begin
          user_key_valid_out <= 1'b1;
          user_key_out       <= r_key;
          r_state            <= S_KEY_LOAD;
        end

        S_KEY_LOAD: begin
          r_cnt   <= '0;
          r_state <= S_KEY_WAIT;
        end

        S_KEY_WAIT: begin
          if (key_exp_ready_in) begin
            r_cache_vld        <= 1'b1;
            r_cache_key        <= r_key;
            r_cache_mode       <= r_mode;
            user_key_valid_out <= 1'b0;
            encdec_enable_out  <= 1'b1;
            valid_out          <= 1'b1;
            data_out           <= r_data;
            r_state            <= S_DATA_SEND;
          end else if (w_expired) begin
            r_cache_vld        <= 1'b0;
            sm4_enable_out     <= 1'b0;
            enable_key_exp_out <= 1'b0;
            encdec_enable_out  <= 1'b0;
            user_key_valid_out <= 1'b0;
            rsp_error          <= 1'b1;
            rsp_data           <= '0;
            rsp_valid          <= 1'b1;
            r_state            <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DATA_SEND: begin
          valid_out <= 1'b0;
          r_cnt     <= '0;
          r_state   <= S_DATA_WAIT;
        end

        S_DATA_WAIT: begin
          if (ready_in) begin
            rsp_data  <= result_in;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            r_state   <= S_RESP;
          end else if (w_expired) begin
            r_cache_vld        <= 1'b0;
            sm4_enable_out     <= 1'b0;
            enable_key_exp_out <= 1'b0;
            encdec_enable_out  <= 1'b0;
            user_key_valid_out <= 1'b0;
            rsp_error          <= 1'b1;
            rsp_data           <= '0;
            rsp_valid          <= 1'b1;
            r_state            <= S_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_RESP: begin
          // Core enables are left alone here so a cached key survives into the next command.
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            r_state   <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sm4_cmd_master.sv
// tb/tb_sm4_cmd_master.sv - directed self-checking bench for sm4_cmd_master
// A behavioural core stub answers with the published SM4 vector pair.
module tb_sm4_cmd_master;

  localparam logic [127:0] K   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] P   = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [127:0] C   = 128'h681edf34d206965e86b3e94f536e4246;
  localparam logic [127:0] C2  = 128'h681edf34d206965e86b3e94f536e4245;
  localparam logic [127:0] PAT = {4{32'ha5a5a5a5}};

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_decrypt = 1'b0;
  logic [127:0] cmd_key = '0;
  logic [127:0] cmd_data = '0;
  logic         rsp_valid;
  logic         rsp_ready = 1'b0;
  logic [127:0] rsp_data;
  logic         rsp_error;
  logic         sm4_enable_out, encdec_enable_out, encdec_sel_out;
  logic         enable_key_exp_out, user_key_valid_out, valid_out;
  logic [127:0] user_key_out, data_out;
  logic         key_exp_ready_in = 1'b0;
  logic         ready_in = 1'b0;
  logic [127:0] result_in = '0;

  int checks = 0;
  int errors = 0;
  logic mute = 1'b0;

  always #5 clk = ~clk;

  sm4_cmd_master #(.TIMEOUT(8), .FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
    .cmd_key(cmd_key), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .sm4_enable_out(sm4_enable_out), .encdec_enable_out(encdec_enable_out),
    .encdec_sel_out(encdec_sel_out), .enable_key_exp_out(enable_key_exp_out),
    .user_key_valid_out(user_key_valid_out), .valid_out(valid_out),
    .user_key_out(user_key_out), .data_out(data_out),
    .key_exp_ready_in(key_exp_ready_in), .ready_in(ready_in), .result_in(result_in)
  );

  // Core stub: key expansion done 3 cycles after the key is offered, result 3 cycles after the block.
  int           kc = 0;
  int           dc = 0;
  logic         pend = 1'b0;
  logic [127:0] core_key = '0;
  logic         core_mode = 1'b0;
  logic [127:0] din = '0;

  always @(negedge clk) begin
    if (reset) begin
      kc = 0; dc = 0; pend = 1'b0;
      key_exp_ready_in = 1'b0; ready_in = 1'b0;
    end else begin
      ready_in = 1'b0;
      if (user_key_valid_out && enable_key_exp_out) begin
        if (kc < 7) kc++;
        key_exp_ready_in = (kc >= 3) && !mute;
        core_key  = user_key_out;
        core_mode = encdec_sel_out;
      end else begin
        kc = 0;
        key_exp_ready_in = 1'b0;
      end
      if (valid_out && encdec_enable_out) begin
        pend = 1'b1; dc = 0; din = data_out;
      end else if (pend && encdec_enable_out) begin
        dc++;
        if (dc == 3 && !mute) begin
          ready_in = 1'b1;
          pend = 1'b0;
          if (core_key == K && !core_mode && din == P)     result_in = C;
          else if (core_key == K && core_mode && din == C) result_in = P;
          else                                              result_in = din ^ PAT;
        end
      end else begin
        pend = 1'b0;
      end
    end
  end

  int   vo_cnt = 0, ukv_rises = 0, kexp_rises = 0, flush_cyc = 0, rsp_rises = 0;
  logic sel_at_kexp = 1'b0;
  logic p_ukv = 1'b0, p_kexp = 1'b0, p_rsp = 1'b0;

  always @(negedge clk) begin
    if (!reset) begin
      vo_cnt += int'(valid_out);
      if (user_key_valid_out && !p_ukv) ukv_rises++;
      if (enable_key_exp_out && !p_kexp) begin
        kexp_rises++;
        sel_at_kexp = encdec_sel_out;
      end
      if (!sm4_enable_out && !cmd_ready && !rsp_valid) flush_cyc++;
      if (rsp_valid && !p_rsp) rsp_rises++;
    end
    p_ukv = user_key_valid_out; p_kexp = enable_key_exp_out; p_rsp = rsp_valid;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send_cmd(input logic dec, input logic [127:0] key, input logic [127:0] data,
                          output logic vo_next);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_decrypt = dec; cmd_key = key; cmd_data = data;
    @(negedge clk);
    cmd_valid = 1'b0;
    vo_next = valid_out;
  endtask

  task automatic get_rsp(output logic [127:0] d, output logic e);
    int n = 0;
    rsp_ready = 1'b1;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("rsp_wait", rsp_valid, 1);
    d = rsp_data; e = rsp_error;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    logic [127:0] d, d0;
    logic e, vo, stable_v, stable_d, stable_r;
    int s_vo, s_ukv, s_kexp, s_fl, s_rsp, n;

    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_core_out", {sm4_enable_out, encdec_enable_out, encdec_sel_out, enable_key_exp_out,
                         user_key_valid_out, valid_out}, 0);
    chk("rst_data", rsp_data | user_key_out | data_out, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Encrypt, cold cache
    s_vo = vo_cnt; s_kexp = kexp_rises; s_fl = flush_cyc;
    send_cmd(1'b0, K, P, vo);
    get_rsp(d, e);
    chk("enc_data", d, C);
    chk("enc_err", e, 0);
    chk("enc_flush", flush_cyc - s_fl, 2);
    chk("enc_keyload", kexp_rises - s_kexp, 1);
    chk("enc_valid_cycles", vo_cnt - s_vo, 1);

    // Decrypt, mode change forces a flush
    s_kexp = kexp_rises; s_fl = flush_cyc;
    send_cmd(1'b1, K, C, vo);
    get_rsp(d, e);
    chk("dec_data", d, P);
    chk("dec_flush", flush_cyc - s_fl, 2);
    chk("dec_keyload", kexp_rises - s_kexp, 1);
    chk("dec_sel_before_kexp", sel_at_kexp, 1);

    // Back-to-back decrypts with the same key
    send_cmd(1'b1, K, C, vo);
    get_rsp(d, e);
    chk("b2b_first_data", d, P);
    s_ukv = ukv_rises; s_fl = flush_cyc; s_vo = vo_cnt;
    send_cmd(1'b1, K, C2, vo);
    chk("b2b_valid_next_cycle", vo, 1);
    get_rsp(d, e);
    chk("b2b_second_data", d, C2 ^ PAT);
    chk("b2b_no_flush", flush_cyc - s_fl, 0);
    chk("b2b_no_key_load", ukv_rises - s_ukv, 0);
    chk("b2b_valid_cycles", vo_cnt - s_vo, 1);

    // Response backpressure
    send_cmd(1'b0, K, P, vo);
    n = 0;
    while (!rsp_valid && n < 100) begin @(negedge clk); n++; end
    chk("bp_rsp_wait", rsp_valid, 1);
    d0 = rsp_data;
    stable_v = 1'b1; stable_d = 1'b1; stable_r = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (!rsp_valid) stable_v = 1'b0;
      if (rsp_data !== d0) stable_d = 1'b0;
      if (cmd_ready) stable_r = 1'b0;
    end
    chk("bp_valid_held", stable_v, 1);
    chk("bp_data_held", stable_d, 1);
    chk("bp_cmd_ready_low", stable_r, 1);
    chk("bp_data", d0, C);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("bp_cmd_ready_next", cmd_ready, 1);
    chk("bp_rsp_dropped", rsp_valid, 0);

    // Timeout while waiting for the result
    mute = 1'b1;
    send_cmd(1'b0, K, P, vo);
    get_rsp(d, e);
    chk("to_err", e, 1);
    chk("to_data", d, 0);
    chk("to_enable_dropped", sm4_enable_out, 0);
    mute = 1'b0;
    s_kexp = kexp_rises; s_fl = flush_cyc;
    send_cmd(1'b0, K, P, vo);
    get_rsp(d, e);
    chk("to_retry_data", d, C);
    chk("to_retry_flush", flush_cyc - s_fl, 2);
    chk("to_retry_keyload", kexp_rises - s_kexp, 1);

    // Reset during key wait
    mute = 1'b1;
    send_cmd(1'b1, K, C, vo);
    n = 0;
    while (!user_key_valid_out && n < 20) begin @(negedge clk); n++; end
    chk("rm_key_wait_reached", user_key_valid_out, 1);
    repeat (2) @(negedge clk);
    s_rsp = rsp_rises;
    #2 reset = 1'b1;
    #1;
    chk("rm_async_enable", sm4_enable_out, 0);
    chk("rm_async_ctrl", {cmd_ready, rsp_valid, enable_key_exp_out, user_key_valid_out,
                          encdec_enable_out, valid_out}, 0);
    chk("rm_async_data", user_key_out | data_out | rsp_data, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mute = 1'b0;
    @(negedge clk);
    chk("rm_cmd_ready", cmd_ready, 1);
    repeat (5) @(negedge clk);
    chk("rm_no_response", rsp_rises - s_rsp, 0);
    send_cmd(1'b0, K, P, vo);
    get_rsp(d, e);
    chk("rm_enc_data", d, C);
    chk("rm_enc_err", e, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sm4_cmd_master.md
# sm4_cmd_master

Command-level sequencer that drives the `sm4_top` core handshake on behalf of a system master. It accepts one {mode, key, block} command at a time over a valid/ready port and runs the core's enable, key-expansion and block-valid sequence. It waits for the core result and returns it over a valid/ready response port, with a timeout error path. Expanded round keys are reused across commands with the same key and mode.

## Interface
- `TIMEOUT`, 1024: cycles allowed in any core-wait state before the command is aborted; minimum 4.
- `FLUSH_CYCLES`, 2: cycles that `sm4_enable_out` and `enable_key_exp_out` are held low before a new key expansion; minimum 1.
- `clk`  in  1  single clock; all logic is rising-edge.
- `reset`  in  1  asynchronous, active-high reset.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when high together with `cmd_valid`.
- `cmd_decrypt`  in  1  selects decryption when 1 and encryption when 0.
- `cmd_key`  in  128  user key.
- `cmd_data`  in  128  input block.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  response consumed.
- `rsp_data`  out  128  result block; 0 on error.
- `rsp_error`  out  1  timeout flag, qualified by `rsp_valid`.
- `sm4_enable_out`, `encdec_enable_out`, `encdec_sel_out`, `enable_key_exp_out`, `user_key_valid_out`, `valid_out`  out  1 each  drive the like-named `sm4_top` `*_in` ports.
- `user_key_out`, `data_out`  out  128 each  drive `sm4_top` `user_key_in` and `data_in`.
- `key_exp_ready_in`, `ready_in`  in  1 each  from `sm4_top` `key_exp_ready_out` and `ready_out`.
- `result_in`  in  128  from `sm4_top` `result_out`.

## Operation
- States: IDLE, FLUSH, KEY_SETUP, KEY_LOAD, KEY_WAIT, DATA_SEND, DATA_WAIT, RESP.
- **IDLE**
  - `cmd_ready`=1 only in this state.
  - On handshake, latch mode, key and data.
  - Cache hit (`cache_vld` and key==cached key and mode==cached mode): go to DATA_SEND.
  - Otherwise: go to FLUSH.
- **FLUSH**
  - Clear `cache_vld`.
  - Drive `sm4_enable_out`=0, `enable_key_exp_out`=0, `encdec_enable_out`=0 for `FLUSH_CYCLES` cycles, then go to KEY_SETUP.
- **KEY_SETUP** (1 cycle)
  - `sm4_enable_out`=1, `enable_key_exp_out`=1.
  - `encdec_sel_out` is set to the latched mode here and is held until the next FLUSH.
- **KEY_LOAD** (1 cycle)
  - `user_key_valid_out`=1, `user_key_out`=latched key.
- **KEY_WAIT**
  - `user_key_valid_out` stays 1, `enable_key_exp_out` stays 1.
  - On `key_exp_ready_in`=1: set `cache_vld`, store key and mode, go to DATA_SEND.
- **DATA_SEND** (1 cycle)
  - `encdec_enable_out`=1, `valid_out`=1, `data_out`=latched data.
- **DATA_WAIT**
  - `valid_out`=0, `encdec_enable_out` stays 1.
  - On `ready_in`=1: capture `result_in` into `rsp_data`, `rsp_error`=0, go to RESP.
- **RESP**
  - `rsp_valid`=1; `rsp_data` and `rsp_error` are held stable until `rsp_ready`=1.
  - Then go to IDLE. Core enables stay asserted so a cached key remains usable.
- **Timeout**
  - A counter is cleared on entry to KEY_WAIT and to DATA_WAIT, and increments each cycle in those states.
  - When it reaches `TIMEOUT`-1 without the awaited input: `rsp_error`=1, `rsp_data`=0, clear `cache_vld`, drop all core enables, go to RESP.
- `ready_in` or `key_exp_ready_in` asserted outside its wait state is ignored.
- `cmd_valid` is ignored outside IDLE. Commands are never queued.

## Timing
- Reset (asynchronous assert):
  - State goes to IDLE; `cache_vld`=0.
  - Every output is 0, including `cmd_ready`, `rsp_valid`, `rsp_data`, `rsp_error` and every core-side output.
  - `cmd_ready` rises on the first clock edge after reset deasserts.
- Reset mid-command: the command is discarded and no response is produced. The core sees `sm4_enable_out`=0 immediately.
- Cache-hit latency:
  - Handshake at edge N.
  - `valid_out` is high for exactly cycle N+1.
  - The result is captured at the first edge where `ready_in`=1.
  - `rsp_valid` is high in the following cycle.
- Miss path before DATA_SEND: `FLUSH_CYCLES` + 2 cycles, plus the key-wait time.
- `valid_out` and the `user_key_valid_out` rise are each single-cycle per command.
- `data_out` and `user_key_out` are registered and stable while their valid is high.
- Response and command are the same cycle-boundary: `rsp_valid`&&`rsp_ready` at edge M gives `cmd_ready`=1 in cycle M+1.

## Test plan
- **Encrypt, cold cache.** Key 0123456789abcdeffedcba9876543210 and data 0123456789abcdeffedcba9876543210 with a real `sm4_top` attached.
  - `rsp_data`=681edf34d206965e86b3e94f536e4246, `rsp_error`=0.
  - One FLUSH is observed and `valid_out` is high for one cycle.
- **Decrypt, cold cache.** Same key, data 681edf34d206965e86b3e94f536e4246.
  - FLUSH occurs because the mode changed; `encdec_sel_out`=1 before `enable_key_exp_out` rises.
  - `rsp_data`=0123456789abcdeffedcba9876543210.
- **Back-to-back decrypts, same key.** Data …4246 then …4245.
  - The second command shows no FLUSH and no `user_key_valid_out` rise.
  - `valid_out` is high in the cycle after the second handshake.
  - The first result equals the plaintext vector.
- **Response backpressure.** Hold `rsp_ready`=0 for 20 cycles.
  - `rsp_valid` and `rsp_data` stay stable and `cmd_ready` stays 0.
  - Release: the handshake occurs and `cmd_ready`=1 on the next cycle.
- **Timeout.** Core stub never asserts `ready_in`, `TIMEOUT`=8.
  - Response has `rsp_error`=1 and `rsp_data`=0.
  - The next command with the same key performs a full FLUSH/key load.
- **Reset mid-operation.** Assert `reset` during KEY_WAIT.
  - All outputs are 0 asynchronously and no response is produced.
  - After release, `cmd_ready`=1 and a new encrypt returns 681edf34….
